// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard sequencer: FSM state encoding and widths.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MUL_WAIT   = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MUL_LATENCY_DEF = 4;
  localparam int         PERF_W          = 16;
  localparam int         CNT_W           = 4;

endpackage

// File: rtl/hazard_controller_load_use.sv
// Load-use compare: a load in EX whose non-zero destination feeds the ID instruction.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             i_idex_memread,
  input  logic [REG_W-1:0] i_idex_rt,
  input  logic [REG_W-1:0] i_ifid_rs,
  input  logic [REG_W-1:0] i_ifid_rt,
  input  logic             i_ifid_uses_rt,
  output logic             o_hazard
);

  logic w_rt_nonzero;
  logic w_rs_match;
  logic w_rt_match;

  assign w_rt_nonzero = (i_idex_rt != REG_W'(REG_ZERO));
  assign w_rs_match   = (i_idex_rt == i_ifid_rs);
  assign w_rt_match   = i_ifid_uses_rt && (i_idex_rt == i_ifid_rt);
  assign o_hazard     = i_idex_memread && w_rt_nonzero && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use bubble, taken-branch flush, multiply freeze.
// Optional saturating perf counters are built when HAZARD_PERF_EN is defined.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int REG_W       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               IDEX_MemRead,
  input  logic [REG_W-1:0]   IDEX_Rt,
  input  logic               IDEX_IsMul,
  input  logic [REG_W-1:0]   IFID_Rs,
  input  logic [REG_W-1:0]   IFID_Rt,
  input  logic               IFID_UsesRt,
  input  logic               Branch_Taken,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic               IDEXWrite,
  output logic               IDEX_Bubble,
  output logic               IFID_Flush,
  output logic               EXMEM_Bubble,
  output logic               Mul_Start,
  output logic               Mul_Busy,
  output logic [PERF_W-1:0]  Perf_LoadStalls,
  output logic [PERF_W-1:0]  Perf_MulStalls,
  output logic [PERF_W-1:0]  Perf_Flushes
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mul_done;
  state_t             w_next_state;
  logic [CNT_W-1:0]   w_next_cnt;
  logic               w_hazard_raw;
  logic               w_hazard;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .i_idex_memread (IDEX_MemRead),
    .i_idex_rt      (IDEX_Rt),
    .i_ifid_rs      (IFID_Rs),
    .i_ifid_rt      (IFID_Rt),
    .i_ifid_uses_rt (IFID_UsesRt),
    .o_hazard       (w_hazard_raw)
  );

  // Masked outside RUN so the held load in LOAD_STALL cannot bubble twice.
  assign w_hazard = w_hazard_raw && (r_state == RUN);

  always_comb begin
    w_next_state = RUN;
    w_next_cnt   = r_cnt;
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IDEXWrite    = 1'b1;
    IDEX_Bubble  = 1'b0;
    IFID_Flush   = 1'b0;
    EXMEM_Bubble = 1'b0;
    Mul_Start    = 1'b0;
    Mul_Busy     = 1'b0;
    if (!rst_n) begin
      PCWrite      = 1'b0;
      IFIDWrite    = 1'b0;
      IDEX_Bubble  = 1'b1;
      IFID_Flush   = 1'b1;
      EXMEM_Bubble = 1'b1;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        RUN, LOAD_STALL: begin
          if (Branch_Taken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
          end else if ((r_state == RUN) && IDEX_IsMul && !r_mul_done) begin
            Mul_Start    = 1'b1;
            Mul_Busy     = 1'b1;
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXWrite    = 1'b0;
            EXMEM_Bubble = 1'b1;
            w_next_cnt   = CNT_W'(MUL_LATENCY - 1);
            w_next_state = MUL_WAIT;
          end else if (w_hazard) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEX_Bubble  = 1'b1;
            w_next_state = LOAD_STALL;
          end
        end
        MUL_WAIT: begin
          Mul_Busy     = 1'b1;
          PCWrite      = 1'b0;
          IFIDWrite    = 1'b0;
          IDEXWrite    = 1'b0;
          EXMEM_Bubble = 1'b1;
          w_next_cnt   = r_cnt - 1'b1;
          if (r_cnt != CNT_W'(1)) w_next_state = MUL_WAIT;
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_mul_done <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      // The multiply stays in EX for one RUN cycle after the freeze; do not restart it.
      if ((r_state == MUL_WAIT) && (r_cnt == CNT_W'(1)))
        r_mul_done <= 1'b1;
      else if (IDEXWrite)
        r_mul_done <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_perf_load_stalls;
  logic [PERF_W-1:0] r_perf_mul_stalls;
  logic [PERF_W-1:0] r_perf_flushes;
  logic              w_load_ev;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != {PERF_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  // With reset released, PC held without a multiply in flight is exactly a load bubble.
  assign w_load_ev = rst_n && !PCWrite && !Mul_Busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_load_stalls <= '0;
      r_perf_mul_stalls  <= '0;
      r_perf_flushes     <= '0;
    end else begin
      r_perf_load_stalls <= sat_inc(r_perf_load_stalls, w_load_ev);
      r_perf_mul_stalls  <= sat_inc(r_perf_mul_stalls, Mul_Busy);
      r_perf_flushes     <= sat_inc(r_perf_flushes, IFID_Flush);
    end
  end

  assign Perf_LoadStalls = r_perf_load_stalls;
  assign Perf_MulStalls  = r_perf_mul_stalls;
  assign Perf_Flushes    = r_perf_flushes;
`else
  assign Perf_LoadStalls = '0;
  assign Perf_MulStalls  = '0;
  assign Perf_Flushes    = '0;
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core. Sits alongside the EX-stage operand forwarding logic.
- Handles three cases:
  - load-use: inserts exactly one bubble.
  - branch taken in EX: flushes IF/ID and ID/EX.
  - multi-cycle multiply in EX: freezes the front of the pipe for MUL_LATENCY cycles.
- Drives PC, IF/ID and ID/EX write-enables plus bubble/flush controls.

Parameters:
- MUL_LATENCY, 4, EX-stage multiplier cycles (legal 2..15).
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_Rt  in  REG_W  load destination in EX
- IDEX_IsMul  in  1  instruction in EX is a multiply
- IFID_Rs  in  REG_W  ID source register 1
- IFID_Rt  in  REG_W  ID source register 2
- IFID_UsesRt  in  1  ID instruction reads Rt
- Branch_Taken  in  1  branch in EX resolved taken
- PCWrite  out  1  PC load enable
- IFIDWrite  out  1  IF/ID register enable
- IDEXWrite  out  1  ID/EX register enable
- IDEX_Bubble  out  1  zero control fields entering ID/EX
- IFID_Flush  out  1  load NOP into IF/ID
- EXMEM_Bubble  out  1  zero control fields entering EX/MEM
- Mul_Start  out  1  one-cycle start strobe to multiplier
- Mul_Busy  out  1  multiplier occupying EX
- Perf_LoadStalls  out  16  load-use stall count
- Perf_MulStalls  out  16  multiply freeze-cycle count
- Perf_Flushes  out  16  branch flush count

Behaviour:
- One clock (clk); reset synchronous, active-low (rst_n). State and counter registered. Outputs combinational from state, inputs and rst_n.
- States: RUN, LOAD_STALL, MUL_WAIT. 4-bit down-counter cnt.
- While rst_n=0 (forced on outputs, not only on the registers):
  - PCWrite=0, IFIDWrite=0, IDEXWrite=1, IDEX_Bubble=1, IFID_Flush=1, EXMEM_Bubble=1
  - Mul_Start=0, Mul_Busy=0
  - next state RUN, cnt=0, perf counters 0
- Default outputs in RUN with no hazard: PCWrite=1, IFIDWrite=1, IDEXWrite=1; all bubbles, flushes and strobes 0.
- Load-use hazard, defined as IDEX_MemRead=1 AND IDEX_Rt!=0 AND (IDEX_Rt==IFID_Rs OR (IFID_UsesRt AND IDEX_Rt==IFID_Rt)):
  - in RUN: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; next state LOAD_STALL.
  - LOAD_STALL lasts exactly one cycle with normal RUN outputs, then RUN.
  - The hazard term is masked in LOAD_STALL so a repeated compare cannot give a second bubble.
- Branch_Taken in RUN or LOAD_STALL: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; next state RUN.
  - Branch has priority over load-use in the same cycle; no stall is taken.
- IDEX_IsMul=1 in RUN with Branch_Taken=0:
  - Mul_Start=1 for that cycle, Mul_Busy=1, PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEM_Bubble=1.
  - Load cnt=MUL_LATENCY-1; next state MUL_WAIT.
- MUL_WAIT:
  - Mul_Busy=1, PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEM_Bubble=1; Branch_Taken and load-use ignored.
  - cnt decrements each cycle; when cnt==1 next state RUN.
  - In the first RUN cycle after, IDEX_IsMul is treated as already serviced (mul_done flag, cleared when IDEXWrite=1).
  - Total front-end freeze = MUL_LATENCY cycles.
- IDEX_IsMul and Branch_Taken both 1 is illegal; branch wins and no Mul_Start is issued.
- Reset asserted mid-MUL_WAIT or mid-LOAD_STALL aborts immediately: RUN next cycle, Mul_Busy=0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: Perf_* are 16-bit saturating counters (stick at 16'hFFFF), cleared by rst_n.
  - LoadStalls +1 per load-use bubble.
  - MulStalls +1 per frozen cycle.
  - Flushes +1 per Branch_Taken acted on.
- Undefined: the three Perf_* ports exist but are tied to 16'h0000; no counter flops.

Decomposition:
- Package hazard_pkg holds: state encoding (RUN=2'd0, LOAD_STALL=2'd1, MUL_WAIT=2'd2), REG_ZERO=5'd0, default MUL_LATENCY, perf counter width 16.
- One sub-module, load_use_detect: the combinational compare above, producing a single hazard bit. Reused by the bench as reference model.

Test Plan:
- lw $8 in EX (IDEX_MemRead=1, IDEX_Rt=8), IFID_Rs=8 -> one cycle PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; following cycle all normal; Perf_LoadStalls=1.
- IDEX_Rt=0, IFID_Rs=0, IDEX_MemRead=1 -> no stall. Separately, IFID_Rt=8 with IFID_UsesRt=0 -> no stall.
- Load-use hazard plus Branch_Taken=1 in the same cycle -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, no stall cycle; Perf_Flushes=1, Perf_LoadStalls=0.
- IDEX_IsMul=1 with MUL_LATENCY=4 -> Mul_Start high 1 cycle; Mul_Busy and PCWrite=0 for exactly 4 cycles; back to RUN; no second Mul_Start while the same mul stays in EX.
- rst_n=0 during the 2nd MUL_WAIT cycle -> outputs at reset values that cycle; RUN with Mul_Busy=0 after release.
- With HAZARD_PERF_EN, preload 65535 load stalls (force) and add one more -> Perf_LoadStalls stays 16'hFFFF. Without the macro, all Perf_* read 0.
